// File: rtl/data_ram_resp_if.sv
// Core load/store and debug-loader bus for the data RAM responder.
// Master is the core/loader side, slave is the RAM.
interface data_ram_resp_if #(
  parameter int WIDTH = 32
);
  logic [WIDTH-1:0] mem_rd_addr_i;
  logic             mem_rd_req_i;
  logic [WIDTH-1:0] mem_rd_data_o;
  logic [WIDTH-1:0] mem_wr_addr_i;
  logic [WIDTH-1:0] mem_wr_data_i;
  logic [3:0]       mem_wr_sel_i;
  logic             dbg_wr_valid_i;
  logic             dbg_wr_ready_o;
  logic [WIDTH-1:0] dbg_wr_addr_i;
  logic [WIDTH-1:0] dbg_wr_data_i;
  logic             init_busy_o;
  logic             addr_err_o;

  modport master (
    output mem_rd_addr_i, mem_rd_req_i,
    output mem_wr_addr_i, mem_wr_data_i,
    output mem_wr_sel_i,
    output dbg_wr_valid_i, dbg_wr_addr_i,
    output dbg_wr_data_i,
    input  mem_rd_data_o, dbg_wr_ready_o,
    input  init_busy_o, addr_err_o
  );

  modport slave (
    input  mem_rd_addr_i, mem_rd_req_i,
    input  mem_wr_addr_i, mem_wr_data_i,
    input  mem_wr_sel_i,
    input  dbg_wr_valid_i, dbg_wr_addr_i,
    input  dbg_wr_data_i,
    output mem_rd_data_o, dbg_wr_ready_o,
    output init_busy_o, addr_err_o
  );
endinterface

// File: rtl/data_ram_resp.sv
// Word-organised 1R1W data RAM: registered read, byte-lane writes,
// same-edge forwarding, post-reset zero-fill and a debug preload port.
module data_ram_resp #(
  parameter int WIDTH   = 32,
  parameter int AW      = 10,
  parameter int INIT_EN = 1
) (
  input logic            clk,
  input logic            rst_n,
  data_ram_resp_if.slave bus
);
  localparam int DEPTH = 2 ** AW;

  typedef enum logic {
    S_INIT,
    S_RUN
  } state_t;

  state_t state, state_nx;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    fill_cnt;
  logic [WIDTH-1:0] rd_data;
  logic             err;

  logic             busy, run, ready;
  logic             rd_ok, wr_ok, dbg_ok;
  logic [AW-1:0]    rd_idx, wr_idx_a, dbg_idx;
  logic             core_wr, dbg_fire, err_set;

  logic             wr_en;
  logic [AW-1:0]    wr_idx;
  logic [WIDTH-1:0] wr_data;
  logic [3:0]       wr_be;
  logic [WIDTH-1:0] rd_old, rd_fwd;
  logic             unused_lsb;

  assign rd_idx   = bus.mem_rd_addr_i[AW+1:2];
  assign wr_idx_a = bus.mem_wr_addr_i[AW+1:2];
  assign dbg_idx  = bus.dbg_wr_addr_i[AW+1:2];

  assign rd_ok  = bus.mem_rd_addr_i[WIDTH-1:AW+2] == '0;
  assign wr_ok  = bus.mem_wr_addr_i[WIDTH-1:AW+2] == '0;
  assign dbg_ok = bus.dbg_wr_addr_i[WIDTH-1:AW+2] == '0;

  assign unused_lsb = ^{bus.mem_rd_addr_i[1:0],
                        bus.mem_wr_addr_i[1:0],
                        bus.dbg_wr_addr_i[1:0]};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= (INIT_EN != 0) ? S_INIT : S_RUN;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      S_INIT: if (&fill_cnt) state_nx = S_RUN;
      S_RUN:  state_nx = S_RUN;
    endcase
  end

  always_comb begin
    busy  = 1'b0;
    run   = 1'b0;
    ready = 1'b0;
    unique case (state)
      S_INIT: busy = 1'b1;
      S_RUN: begin
        run   = 1'b1;
        ready = bus.mem_wr_sel_i == 4'b0000;
      end
    endcase
  end

  assign bus.init_busy_o    = busy;
  assign bus.dbg_wr_ready_o = ready;

  assign core_wr  = run && (bus.mem_wr_sel_i != 4'b0000);
  assign dbg_fire = bus.dbg_wr_valid_i && ready;

  // Single write port: fill beats core, core beats debug
  always_comb begin
    wr_en   = 1'b0;
    wr_idx  = fill_cnt;
    wr_data = '0;
    wr_be   = 4'b0000;
    if (busy) begin
      wr_en = 1'b1;
      wr_be = 4'b1111;
    end else if (core_wr) begin
      wr_en   = wr_ok;
      wr_idx  = wr_idx_a;
      wr_data = bus.mem_wr_data_i;
      wr_be   = bus.mem_wr_sel_i;
    end else if (dbg_fire) begin
      wr_en   = dbg_ok;
      wr_idx  = dbg_idx;
      wr_data = bus.dbg_wr_data_i;
      wr_be   = 4'b1111;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) begin
      for (int k = 0; k < 4; k++) begin
        if (wr_be[k]) mem[wr_idx][8*k +: 8] <= wr_data[8*k +: 8];
      end
    end
  end

  assign rd_old = mem[rd_idx];

  always_comb begin
    rd_fwd = rd_old;
    for (int k = 0; k < 4; k++) begin
      if (wr_en && wr_be[k] && (wr_idx == rd_idx))
        rd_fwd[8*k +: 8] = wr_data[8*k +: 8];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                rd_data <= '0;
    else if (bus.mem_rd_req_i) rd_data <= (run && rd_ok) ? rd_fwd : '0;
  end

  assign err_set = run && ((bus.mem_rd_req_i && !rd_ok) ||
                           (core_wr && !wr_ok) ||
                           (dbg_fire && !dbg_ok));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)       err <= 1'b0;
    else if (err_set) err <= 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)    fill_cnt <= '0;
    else if (busy) fill_cnt <= fill_cnt + AW'(1);
  end

  assign bus.mem_rd_data_o = rd_data;
  assign bus.addr_err_o    = err;
endmodule

// File: tb/tb_data_ram_resp.sv
// Scoreboard bench for data_ram_resp (AW=4): reads push expected data,
// a monitor pops and compares one cycle after each captured request.
module tb_data_ram_resp;
  logic clk;
  logic rst_n;

  data_ram_resp_if #(.WIDTH(32)) bus ();

  data_ram_resp #(
    .WIDTH  (32),
    .AW     (4),
    .INIT_EN(1)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  int total;
  int passed;
  logic [31:0] expq[$];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  initial begin
    logic fire;
    logic [31:0] e;
    forever begin
      @(posedge clk);
      fire = bus.mem_rd_req_i && rst_n;
      @(negedge clk);
      if (fire) begin
        if (expq.size() == 0) begin
          check("rd_unexpected", 32'd1, 32'd0);
        end else begin
          e = expq.pop_front();
          check("rd_data", bus.mem_rd_data_o, e);
        end
      end
    end
  end

  task automatic rd(logic [31:0] a, logic [31:0] e);
    bus.mem_rd_req_i  = 1'b1;
    bus.mem_rd_addr_i = a;
    expq.push_back(e);
    @(negedge clk);
    bus.mem_rd_req_i = 1'b0;
  endtask

  task automatic cwr(logic [31:0] a, logic [31:0] d, logic [3:0] s);
    bus.mem_wr_addr_i = a;
    bus.mem_wr_data_i = d;
    bus.mem_wr_sel_i  = s;
    @(negedge clk);
    bus.mem_wr_sel_i = 4'b0000;
  endtask

  task automatic dbg_wr(logic [31:0] a, logic [31:0] d);
    int n;
    bus.dbg_wr_valid_i = 1'b1;
    bus.dbg_wr_addr_i  = a;
    bus.dbg_wr_data_i  = d;
    #1;
    n = 0;
    while (!bus.dbg_wr_ready_o && n < 50) begin
      @(negedge clk);
      #1;
      n++;
    end
    if (n >= 50) check("dbg_timeout", 32'd1, 32'd0);
    @(negedge clk);
    bus.dbg_wr_valid_i = 1'b0;
  endtask

  task automatic wait_init(string name);
    int n;
    n = 0;
    while (bus.init_busy_o && n < 100) begin
      @(negedge clk);
      n++;
    end
    check(name, 32'(n), 32'd16);
  endtask

  initial begin
    total  = 0;
    passed = 0;
    rst_n  = 1'b0;
    bus.mem_rd_addr_i  = '0;
    bus.mem_rd_req_i   = 1'b0;
    bus.mem_wr_addr_i  = '0;
    bus.mem_wr_data_i  = '0;
    bus.mem_wr_sel_i   = 4'b0000;
    bus.dbg_wr_valid_i = 1'b0;
    bus.dbg_wr_addr_i  = '0;
    bus.dbg_wr_data_i  = '0;

    @(negedge clk);
    #1;
    check("rst_data", bus.mem_rd_data_o, 32'h0);
    check("rst_err", 32'(bus.addr_err_o), 32'd0);
    check("rst_busy", 32'(bus.init_busy_o), 32'd1);
    check("rst_ready", 32'(bus.dbg_wr_ready_o), 32'd0);

    @(negedge clk);
    rst_n = 1'b1;
    wait_init("init_len");
    #1;
    check("ready_run", 32'(bus.dbg_wr_ready_o), 32'd1);
    @(negedge clk);

    for (int i = 0; i < 16; i++) rd(32'(i * 4), 32'h0);

    dbg_wr(32'h8, 32'h11223344);
    cwr(32'h8, 32'h0000AA00, 4'b0010);
    rd(32'h8, 32'h1122AA44);

    dbg_wr(32'h10, 32'hDEADBEEF);
    bus.mem_rd_req_i  = 1'b1;
    bus.mem_rd_addr_i = 32'h10;
    bus.mem_wr_addr_i = 32'h10;
    bus.mem_wr_data_i = 32'h01000002;
    bus.mem_wr_sel_i  = 4'b1001;
    expq.push_back(32'h01ADBE02);
    @(negedge clk);
    bus.mem_rd_req_i = 1'b0;
    bus.mem_wr_sel_i = 4'b0000;
    rd(32'h10, 32'h01ADBE02);

    bus.dbg_wr_valid_i = 1'b1;
    bus.dbg_wr_addr_i  = 32'h24;
    bus.dbg_wr_data_i  = 32'hCAFEF00D;
    bus.mem_rd_req_i   = 1'b1;
    bus.mem_rd_addr_i  = 32'h24;
    expq.push_back(32'hCAFEF00D);
    @(negedge clk);
    bus.dbg_wr_valid_i = 1'b0;
    bus.mem_rd_req_i   = 1'b0;
    @(negedge clk);
    check("rd_hold", bus.mem_rd_data_o, 32'hCAFEF00D);

    bus.dbg_wr_valid_i = 1'b1;
    bus.dbg_wr_addr_i  = 32'h14;
    bus.dbg_wr_data_i  = 32'h0BADC0DE;
    for (int i = 0; i < 3; i++) begin
      bus.mem_wr_addr_i = 32'(32'h18 + i * 4);
      bus.mem_wr_data_i = 32'(32'hA0A0A0A0 + i);
      bus.mem_wr_sel_i  = 4'b1111;
      #1;
      check("arb_ready_low", 32'(bus.dbg_wr_ready_o), 32'd0);
      @(negedge clk);
    end
    bus.mem_wr_sel_i = 4'b0000;
    #1;
    check("arb_ready_high", 32'(bus.dbg_wr_ready_o), 32'd1);
    @(negedge clk);
    bus.dbg_wr_valid_i = 1'b0;
    rd(32'h14, 32'h0BADC0DE);
    rd(32'h18, 32'hA0A0A0A0);
    rd(32'h1C, 32'hA0A0A0A1);
    rd(32'h20, 32'hA0A0A0A2);
    check("err_clear", 32'(bus.addr_err_o), 32'd0);

    cwr(32'h4, 32'h55667788, 4'b1111);
    cwr(32'h40, 32'hFFFFFFFF, 4'b1111);
    #1;
    check("err_wr_oor", 32'(bus.addr_err_o), 32'd1);
    rd(32'h0, 32'h0);
    rd(32'h44, 32'h0);
    rd(32'h4, 32'h55667788);
    repeat (3) @(negedge clk);
    check("err_sticky", 32'(bus.addr_err_o), 32'd1);

    rst_n = 1'b0;
    #1;
    check("rst2_data", bus.mem_rd_data_o, 32'h0);
    check("rst2_err", 32'(bus.addr_err_o), 32'd0);
    check("rst2_busy", 32'(bus.init_busy_o), 32'd1);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (7) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("rst3_busy", 32'(bus.init_busy_o), 32'd1);
    check("rst3_ready", 32'(bus.dbg_wr_ready_o), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    wait_init("init_len2");
    @(negedge clk);
    rd(32'h8, 32'h0);
    rd(32'h18, 32'h0);

    repeat (3) @(negedge clk);
    check("queue_empty", 32'(expq.size()), 32'd0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule

// File: doc/data_ram_resp.md
Name: data_ram_resp

Overview:
- Data-memory responder for the core's load/store interface. It sits at the far end of the core's read port (mem_rd_addr/mem_rd_req/mem_rd_data) and write port (mem_wr_addr/mem_wr_data/mem_wr_sel).
- Provides a word-organised 1R1W RAM with one-cycle registered read, byte-select writes and same-cycle read/write forwarding.
- After reset, a zero-fill state machine clears the array.
- A valid/ready debug write port allows a loader to preload data behind core stores.

Parameters:
- WIDTH, 32, data/address width in bits; must be 32 (4 byte lanes).
- AW, 10, word-address bits; array depth DEPTH = 2**AW words.
- INIT_EN, 1, 1 = run zero-fill after reset; 0 = enter RUN directly with array contents undefined.

Ports:
- clk  input  1  clock, all state on rising edge.
- rst_n  input  1  asynchronous active-low reset.
- mem_rd_addr_i  input  WIDTH  byte read address from core.
- mem_rd_req_i  input  1  read request.
- mem_rd_data_o  output  WIDTH  registered read data.
- mem_wr_addr_i  input  WIDTH  byte write address from core.
- mem_wr_data_i  input  WIDTH  write data, lane-aligned.
- mem_wr_sel_i  input  4  byte enables; bit k enables bits [8k+7:8k]; 4'b0000 means no write.
- dbg_wr_valid_i  input  1  debug write valid.
- dbg_wr_ready_o  output  1  debug write ready.
- dbg_wr_addr_i  input  WIDTH  debug byte address.
- dbg_wr_data_i  input  WIDTH  debug full-word data.
- init_busy_o  output  1  high while zero-fill runs.
- addr_err_o  output  1  sticky flag: an out-of-range access was attempted.

Behaviour:
- Address decode:
  - Word index = addr[AW+1:2]; addr[1:0] is ignored (no misalignment check).
  - An address is in range iff addr[WIDTH-1:AW+2] == 0.
  - Out-of-range write: dropped, and addr_err_o is set.
  - Out-of-range read: returns 0 and sets addr_err_o.
  - addr_err_o is cleared only by reset.
- Reset (async, rst_n=0):
  - mem_rd_data_o=0, addr_err_o=0, fill counter=0.
  - State = INIT (INIT_EN=1) or RUN (INIT_EN=0).
  - init_busy_o = 1 in INIT, 0 otherwise; dbg_wr_ready_o=0.
  - Array contents are not reset.
- State INIT:
  - Each cycle writes 0 to word[counter], then increments the counter.
  - After the write of word DEPTH-1 (DEPTH cycles after reset release), the next state is RUN and init_busy_o falls.
  - During INIT: core writes are ignored, reads return 0 (mem_rd_data_o updated to 0 on each req), dbg_wr_ready_o=0, no addr_err_o updates.
  - Reset asserted mid-INIT restarts the fill from word 0.
- State RUN: terminal until reset.
- Read:
  - mem_rd_req_i=1 at edge n captures the word; data is valid on mem_rd_data_o after edge n (latency 1).
  - With req=0, mem_rd_data_o holds its last value.
- Write:
  - When mem_wr_sel_i!=0 at edge n, the enabled lanes of the word are written at edge n; unselected lanes are unchanged.
  - A read issued at n+1 sees the new data.
- Forwarding: when a read and a core write hit the same word at the same edge, mem_rd_data_o = per-lane merge:
  - new write bytes on lanes with sel=1;
  - old array bytes on the other lanes.
- Debug port:
  - dbg_wr_ready_o = (state==RUN) && (mem_wr_sel_i==0), combinational.
  - A transfer occurs on valid&&ready and writes the full word.
  - Core writes have priority; valid must be held until ready.
  - Forwarding applies to debug writes as for a core write with sel=4'b1111.
  - An out-of-range debug address is consumed (handshake completes), dropped, and sets addr_err_o.
- Only one array write per cycle: INIT fill, else core write, else debug write.

Test Plan:
- Reset, INIT_EN=1, AW=4: init_busy_o high exactly 16 cycles after rst_n rises. Then a read of any word 0..15 returns 32'h0, and dbg_wr_ready_o rises in the first RUN cycle.
- Byte select:
  - Debug-write 32'h11223344 to addr 0x8.
  - Core writes sel=4'b0010, data 32'h0000AA00 to 0x8.
  - A read of 0x8 on the next cycle returns 32'h1122AA44 one cycle after req.
- Forwarding: word 0x10 holds 32'hDEADBEEF. Same-cycle read 0x10 with core write sel=4'b1001, data 32'h01000002 -> mem_rd_data_o = 32'h01ADBE02.
- Arbitration: dbg_wr_valid_i held high while core writes for 3 cycles -> dbg_wr_ready_o=0 for those cycles. The debug write completes in the first cycle with sel=0, and the core data is intact.
- Out of range (AW=4):
  - A write to 0x40 leaves the array unchanged and sets addr_err_o.
  - A read of 0x44 returns 0; addr_err_o stays 1 until reset.
- Reset mid-INIT: assert rst_n=0 at fill count 7 -> outputs return to reset values immediately. After release, init_busy_o is high for a full 16 cycles again.
